// File: rtl/cpu_multicycle.sv
// Multicycle 16-bit-instruction CPU: a shared ALU sequenced by an FSM, with a req/ready
// data-memory handshake, a HALT instruction and a selectable illegal-opcode policy.
module cpu_multicycle #(
  parameter int DWIDTH          = 8,
  parameter int IWIDTH          = 16,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [DWIDTH-1:0] pc,
  input  logic [IWIDTH-1:0] instr,
  output logic              mem_req,
  output logic              memwrite,
  input  logic              mem_ready,
  output logic [DWIDTH-1:0] aluout,
  output logic [DWIDTH-1:0] writedata,
  input  logic [DWIDTH-1:0] readdata,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_J    = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [DWIDTH-1:0] ZERO_C = {DWIDTH{1'b0}};
  localparam logic [DWIDTH-1:0] ONE_C  = {{(DWIDTH-1){1'b0}}, 1'b1};

  state_t            state_r, state_next_s;
  logic [IWIDTH-1:0] ir_r;
  logic [DWIDTH-1:0] a_r, b_r, mdr_r;
  logic [DWIDTH-1:0] regs_r [0:3];

  logic [3:0]        op_s;
  logic [1:0]        rd_s, rs_s, rt_s;
  logic [DWIDTH-1:0] imm_s, pc_inc_s, alu_s, pc_exec_s;
  logic              illegal_s, halt_dec_s;

  // Sign-extends (or truncates) the 8-bit immediate to the datapath width.
  function automatic logic [DWIDTH-1:0] sext_imm(input logic [7:0] imm);
    return DWIDTH'($signed(imm));
  endfunction

  assign op_s       = ir_r[15:12];
  assign rd_s       = ir_r[11:10];
  assign rs_s       = ir_r[9:8];
  assign rt_s       = ir_r[7:6];
  assign imm_s      = sext_imm(ir_r[7:0]);
  assign pc_inc_s   = pc + ONE_C;
  assign illegal_s  = (op_s >= 4'hB) && (op_s <= 4'hE);
  assign halt_dec_s = (op_s == OP_HALT) || (illegal_s && HALT_ON_ILLEGAL);

  // Shared ALU: arithmetic, address generation and branch-target computation.
  always_comb begin
    alu_s = ZERO_C;
    case (op_s)
      OP_ADD:               alu_s = a_r + b_r;
      OP_SUB:               alu_s = a_r - b_r;
      OP_AND:               alu_s = a_r & b_r;
      OP_OR:                alu_s = a_r | b_r;
      OP_SLT:               alu_s = ($signed(a_r) < $signed(b_r)) ? ONE_C : ZERO_C;
      OP_ADDI, OP_LW, OP_SW: alu_s = a_r + imm_s;
      OP_BEQ:               alu_s = pc_inc_s + imm_s;
      OP_J:                 alu_s = imm_s;
      default:              alu_s = ZERO_C;
    endcase
  end

  // Program-counter value committed by instructions that finish in EXEC.
  always_comb begin
    pc_exec_s = pc_inc_s;
    case (op_s)
      OP_BEQ:  pc_exec_s = (a_r == b_r) ? alu_s : pc_inc_s;
      OP_J:    pc_exec_s = imm_s;
      default: pc_exec_s = pc_inc_s;
    endcase
  end

  // Next-state logic of the instruction sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_FETCH: state_next_s = S_DECODE;
      S_DECODE: begin
        if (halt_dec_s) state_next_s = S_HALT;
        else            state_next_s = S_EXEC;
      end
      S_EXEC: begin
        case (op_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI: state_next_s = S_WB;
          OP_LW, OP_SW:                                   state_next_s = S_MEM;
          default:                                        state_next_s = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (!mem_ready)          state_next_s = S_MEM;
        else if (op_s == OP_LW)  state_next_s = S_WB;
        else                     state_next_s = S_FETCH;
      end
      S_WB:    state_next_s = S_FETCH;
      S_HALT:  state_next_s = S_HALT;
      default: state_next_s = S_FETCH;
    endcase
  end

  // State, datapath registers and registered status/handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_FETCH;
      ir_r      <= {IWIDTH{1'b0}};
      a_r       <= ZERO_C;
      b_r       <= ZERO_C;
      mdr_r     <= ZERO_C;
      pc        <= ZERO_C;
      aluout    <= ZERO_C;
      writedata <= ZERO_C;
      mem_req   <= 1'b0;
      memwrite  <= 1'b0;
      halted    <= 1'b0;
      for (int i = 0; i < 4; i++) regs_r[i] <= ZERO_C;
    end else begin
      state_r  <= state_next_s;
      mem_req  <= (state_next_s == S_MEM);
      memwrite <= (state_next_s == S_MEM) && (op_s == OP_SW);
      halted   <= (state_next_s == S_HALT);
      case (state_r)
        S_FETCH: ir_r <= instr;
        S_DECODE: begin
          a_r <= regs_r[rs_s];
          // Stores and branches take their second operand from the rd field.
          b_r <= ((op_s == OP_SW) || (op_s == OP_BEQ)) ? regs_r[rd_s] : regs_r[rt_s];
        end
        S_EXEC: begin
          aluout <= alu_s;
          if ((op_s == OP_LW) || (op_s == OP_SW)) writedata <= b_r;
          if (state_next_s == S_FETCH) pc <= pc_exec_s;
        end
        S_MEM: begin
          if (mem_ready) begin
            if (op_s == OP_LW) mdr_r <= readdata;
            else               pc    <= pc_inc_s;
          end
        end
        S_WB: begin
          // regs_r[0] is never written, so r0 always reads as zero.
          if (rd_s != 2'd0) regs_r[rd_s] <= (op_s == OP_LW) ? mdr_r : aluout;
          pc <= pc_inc_s;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cpu_multicycle.md
Name: cpu_multicycle

Overview:
- Parametrised multicycle successor to the single-cycle 4-bit-opcode CPU top.
- Executes the same 16-bit instruction format over a shared ALU, sequenced by an internal FSM instead of a single-cycle datapath.
- Adds a req/ready handshake to data memory so it tolerates wait states, a HALT instruction, and a configurable illegal-opcode mode.
- Sits between instruction ROM (combinational on pc) and data RAM.

Parameters:
- DWIDTH, 8, data/register/address width; pc is DWIDTH bits.
- IWIDTH, 16, instruction width; only 16 is legal.
- HALT_ON_ILLEGAL, 0: 1 means opcodes B-E enter HALT; 0 means they execute as NOP.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- pc  out  DWIDTH  instruction index presented to instruction ROM.
- instr  in  IWIDTH  instruction at pc, valid combinationally.
- mem_req  out  1  data-memory access request.
- memwrite  out  1  qualifies mem_req as a write.
- mem_ready  in  1  memory accepts/completes the access this cycle.
- aluout  out  DWIDTH  registered ALU result; memory address during MEM.
- writedata  out  DWIDTH  store data (value of rd).
- readdata  in  DWIDTH  load data, sampled when mem_req & mem_ready.
- halted  out  1  core is stopped in HALT.

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk.
- Reset values: pc=0, state=FETCH, IR=0, all 4 registers=0, aluout=0, writedata=0, mem_req=0, memwrite=0, halted=0. Reset dominates every state, including a pending MEM access.
- Instruction fields:
  - opcode=[15:12], rd=[11:10], rs=[9:8], rt=[7:6], imm=[7:0].
  - imm is sign-extended to DWIDTH; if DWIDTH<8, truncated.
  - Register r0 reads as 0; writes to r0 are discarded.
- Opcodes:
  - 0 NOP.
  - 1 ADD: rd=rs+rt.
  - 2 SUB: rd=rs-rt.
  - 3 AND.
  - 4 OR.
  - 5 SLT: rd=1 if signed rs<rt, else 0.
  - 6 ADDI: rd=rs+imm.
  - 7 LW: rd=mem[rs+imm].
  - 8 SW: mem[rs+imm]=rd.
  - 9 BEQ: if rd==rs then pc=pc+1+imm, else pc+1.
  - A J: pc=imm.
  - F HALT.
  - B-E: illegal, handled per HALT_ON_ILLEGAL.
- Arithmetic is modulo 2^DWIDTH; no flags. pc+1 wraps from 2^DWIDTH-1 to 0.
- FSM:
  - FETCH: IR<=instr. Next state DECODE.
  - DECODE: A<=reg[rs], B<=reg[rt] (for SW/BEQ, B<=reg[rd]). HALT, or illegal with HALT_ON_ILLEGAL=1, goes to HALT; otherwise EXEC.
  - EXEC:
    - aluout<=result (for LW/SW, rs+imm).
    - NOP, BEQ, J, or illegal with HALT_ON_ILLEGAL=0: update pc, then FETCH.
    - ALU ops and ADDI: go to WB.
    - LW/SW: writedata<=B, then MEM.
  - MEM:
    - mem_req=1; memwrite=1 only for SW. aluout and writedata are held stable.
    - Stay in MEM while mem_ready=0.
    - On mem_ready=1, SW does pc<=pc+1 and goes to FETCH; LW latches readdata into MDR and goes to WB.
  - WB: reg[rd]<=result (MDR for LW), pc<=pc+1, then FETCH.
  - HALT: halted=1, pc frozen, no requests. Exits only via reset.
- mem_req and memwrite are asserted only in MEM and are low in every other state.
- Latency with zero wait states:
  - NOP, BEQ, J: 3 cycles.
  - ALU ops, ADDI: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - Each cycle mem_ready is low adds one cycle.
- A register written in WB is visible to the next instruction's DECODE.
- mem_ready outside MEM is ignored.

Test Plan:
- Reset hold: drive reset for 2 cycles, then release. Required: pc=0, mem_req=0, halted=0. The first FETCH samples instr at pc 0.
- ALU sequence: ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; SLT r1,r2,r1; SW r3,0x10(r0). Required: store has address 0x10, writedata 0x02, memwrite=1. Total 20 cycles from reset release with mem_ready tied high.
- Load wait states: mem[0x20]=0xA5, LW r2,0x20(r0), with mem_ready held low 3 cycles. Required: mem_req stays high for 4 cycles with aluout=0x20 stable and memwrite=0. r2=0xA5 confirmed by a following SW.
- Branch and wrap:
  - BEQ r0,r0,-1 at pc 5: next pc=5 (loop).
  - J 0xFF, then NOP at 0xFF: pc wraps to 0x00.
  - BEQ with unequal registers: pc+1.
- HALT: HALT at pc 3. Required: halted=1 three cycles after the FETCH at pc 3, pc stays 3 and mem_req stays 0 for 20 cycles. Reset returns pc to 0 and clears halted.
- Illegal opcode and reset mid-operation:
  - With HALT_ON_ILLEGAL=0, opcode 0xC acts as a NOP.
  - With HALT_ON_ILLEGAL=1, opcode 0xC halts.
  - Reset asserted during MEM with mem_ready=0 drops mem_req the next cycle and clears all registers.
